leaf_stream_merger: RTL and testbench

LEAF_STREAM_MERGER -- requirements
Module: leaf_stream_merger

---
 rtl/leaf_merge_pkg.sv | 19 +
 rtl/leaf_merge_fifo.sv | 59 +++++
 rtl/leaf_stream_merger.sv | 96 +++++++++
 tb/tb_leaf_stream_merger.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/leaf_merge_pkg.sv
// Shared defaults, source-index width and the FIFO entry layout for the leaf stream merger.
package leaf_merge_pkg;

  localparam int NUM_IN = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Ascending successor of a stream index, wrapping back to 0 after n-1.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/leaf_merge_fifo.sv
// Synchronous FIFO of {src, data} entries with naturally wrapping pointers and an occupancy counter.
module leaf_merge_fifo
  import leaf_merge_pkg::*;
#(
  parameter int  DEPTH   = leaf_merge_pkg::DEPTH,
  parameter type entry_t = leaf_merge_pkg::entry_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  entry_t       wr_entry,
  output entry_t       rd_entry,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign rd_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_stream_merger.sv
// Round-robin merge of NUM_IN valid/ready leaf streams into one buffered output stream tagged with its source index.
module leaf_stream_merger
  import leaf_merge_pkg::*;
#(
  parameter int  NUM_IN = leaf_merge_pkg::NUM_IN,
  parameter int  DATA_W = leaf_merge_pkg::DATA_W,
  parameter int  DEPTH  = leaf_merge_pkg::DEPTH,
  localparam int SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         count
);

  // Entry layout follows this instance's widths, which may differ from the package defaults.
  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } merge_entry_t;

  logic [SRC_W-1:0] rr;
  logic [SRC_W-1:0] grant_idx;
  logic             found;
  logic             space;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  int               idx;
  merge_entry_t     wr_entry;
  merge_entry_t     rd_entry;

  assign pop   = !empty && out_ready;
  assign space = !full || pop;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = int'(rr);
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found && in_valid[idx]) begin
        found     = 1'b1;
        grant_idx = SRC_W'(idx);
      end
      idx = next_index(idx, NUM_IN);
    end
  end

  assign push = found && space && !rst;

  always_comb begin
    in_ready = '0;
    if (push) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign wr_entry.src  = grant_idx;
  assign wr_entry.data = in_data[int'(grant_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
    end else if (push) begin
      rr <= SRC_W'(next_index(int'(grant_idx), NUM_IN));
    end
  end

  leaf_merge_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (merge_entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign out_valid = !empty;
  assign out_data  = rd_entry.data;
  assign out_src   = rd_entry.src;

endmodule

// File: tb/tb_leaf_stream_merger.sv
// Directed and randomized checks of the merger against a queue-based reference of the arbitration and FIFO rules.
module tb_leaf_stream_merger;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic [$clog2(D):0] count;

  typedef struct {
    int          src;
    logic [W-1:0] data;
  } word_t;

  word_t        model_q[$];
  int           model_rr;
  int           checks = 0;
  int           errors = 0;
  int           dut_grants[N];
  logic [N-1:0] obs_in_ready;
  logic         obs_out_valid;
  logic [W-1:0] obs_out_data;
  logic [SW-1:0] obs_out_src;
  int           obs_count;
  logic [W-1:0] held_data;
  logic [SW-1:0] held_src;

  leaf_stream_merger #(
    .NUM_IN (N),
    .DATA_W (W),
    .DEPTH  (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive after the falling edge, check against the reference, then advance the reference at the rising edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic r, input logic rs);
    logic [N-1:0] exp_ready;
    logic         space;
    logic         found;
    int           win;
    int           i;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    rst       = rs;
    for (int s = 0; s < N; s++) in_data[s*W +: W] = W'($urandom);
    #1;
    exp_ready = '0;
    found     = 1'b0;
    win       = -1;
    space     = (model_q.size() < D) || (model_q.size() == D && r);
    if (!rs && space) begin
      for (int k = 0; k < N; k++) begin
        i = (model_rr + k) % N;
        if (!found && v[i]) begin
          found        = 1'b1;
          win          = i;
          exp_ready[i] = 1'b1;
        end
      end
    end
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_out_data  = out_data;
    obs_out_src   = out_src;
    obs_count     = int'(count);
    for (int s = 0; s < N; s++) dut_grants[s] += int'(in_ready[s] & v[s]);
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("count", 32'(count), 32'(model_q.size()));
    checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      checkOutput("out_src", 32'(out_src), 32'(model_q[0].src));
      checkOutput("out_data", 32'(out_data), 32'(model_q[0].data));
    end
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_rr = 0;
    end else begin
      if (model_q.size() != 0 && r) void'(model_q.pop_front());
      if (win >= 0) begin
        model_q.push_back('{src: win, data: in_data[win*W +: W]});
        model_rr = (win + 1) % N;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_rr  = 0;
    for (int s = 0; s < N; s++) dut_grants[s] = 0;
    repeat (2) @(posedge clk);

    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("reset_count", 32'(obs_count), 32'd0);
    checkOutput("reset_out_valid", 32'(obs_out_valid), 32'd0);

    // Fill from reset with every stream requesting and no drain.
    for (int g = 0; g < 4; g++) begin
      applyStimulus('1, 1'b0, 1'b0);
      checkOutput("fill_grant", 32'(obs_in_ready), 32'(1 << g));
    end
    applyStimulus('1, 1'b0, 1'b0);
    checkOutput("fill_blocked", 32'(obs_in_ready), 32'd0);
    checkOutput("fill_count", 32'(obs_count), 32'd4);

    // Full FIFO accepts a word when the head pops in the same cycle.
    applyStimulus(5'b00100, 1'b1, 1'b0);
    checkOutput("full_edge_grant", 32'(obs_in_ready), 32'b00100);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("full_edge_count", 32'(obs_count), 32'd4);

    held_data = obs_out_data;
    held_src  = obs_out_src;
    for (int c = 0; c < 3; c++) begin
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("hold_data", 32'(obs_out_data), 32'(held_data));
      checkOutput("hold_src", 32'(obs_out_src), 32'(held_src));
    end
    for (int c = 0; c < 4; c++) applyStimulus('0, 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("drain_count", 32'(obs_count), 32'd0);

    // Sparse requesters alternate from a cleared pointer.
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus(5'b01010, 1'b0, 1'b0);
    checkOutput("sparse_g0", 32'(obs_in_ready), 32'b00010);
    applyStimulus(5'b01010, 1'b0, 1'b0);
    checkOutput("sparse_g1", 32'(obs_in_ready), 32'b01000);
    applyStimulus(5'b01010, 1'b0, 1'b0);
    checkOutput("sparse_g2", 32'(obs_in_ready), 32'b00010);
    applyStimulus(5'b01010, 1'b0, 1'b0);
    checkOutput("sparse_g3", 32'(obs_in_ready), 32'b01000);

    // Fairness over twenty saturated cycles.
    applyStimulus('0, 1'b0, 1'b1);
    for (int s = 0; s < N; s++) dut_grants[s] = 0;
    for (int c = 0; c < 20; c++) applyStimulus('1, 1'b1, 1'b0);
    for (int s = 0; s < N; s++) checkOutput($sformatf("fair_grants_%0d", s), 32'(dut_grants[s]), 32'd4);

    // Reset in the middle of traffic discards the buffered words and the pointer.
    applyStimulus('0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus('1, 1'b0, 1'b0);
    checkOutput("pre_reset_count", 32'(obs_count), 32'd2);
    applyStimulus('1, 1'b0, 1'b1);
    checkOutput("reset_blocks_ready", 32'(obs_in_ready), 32'd0);
    checkOutput("reset_mid_count", 32'(obs_count), 32'd3);
    applyStimulus(5'b10110, 1'b0, 1'b0);
    checkOutput("post_reset_count", 32'(obs_count), 32'd0);
    checkOutput("post_reset_valid", 32'(obs_out_valid), 32'd0);
    checkOutput("post_reset_grant", 32'(obs_in_ready), 32'b00010);

    for (int c = 0; c < 400; c++) begin
      applyStimulus(N'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
